// File: rtl/xframetrim.sv
// xframetrim: keeps the leading N_KEEP samples of each head/tail-flagged
// input frame, regenerates head/tail flags on the trimmed frame and flags
// length and head-position errors. The rest of each frame is discarded.
//
// Optional build macro XFRAMETRIM_STAT_EN adds frame/error statistics
// counters (i_stat_clr, ov_frame_cnt, ov_err_cnt).
//
// Handshake: i_nd qualifies iv_data/i_head/i_tail for one cycle; there is no
// backpressure. o_dv qualifies ov_data/o_head/o_tail for exactly one cycle.
// Error pulses line up with the cycle the matching output appears (or would
// have appeared). All outputs are registered: one clock of latency.
//
// o_dbg_state exposes the FSM state (0=IDLE, 1=KEEP, 2=DISCARD).

module xframetrim #(
    parameter int BWID           = 16,
    parameter int N_FRAME_LENGTH = 1024,
    parameter int N_KEEP         = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BWID-1:0] iv_data,
    input  logic            i_nd,
    input  logic            i_head,
    input  logic            i_tail,
    output logic [BWID-1:0] ov_data,
    output logic            o_dv,
    output logic            o_head,
    output logic            o_tail,
    output logic            o_err_len,
    output logic            o_err_head,
`ifdef XFRAMETRIM_STAT_EN
    input  logic            i_stat_clr,
    output logic [15:0]     ov_frame_cnt,
    output logic [15:0]     ov_err_cnt,
`endif
    output logic [1:0]      o_dbg_state
);

    // Counter holds the index of the next expected sample in the frame.
    localparam int CW = $clog2(N_FRAME_LENGTH) + 1;
    localparam logic [CW-1:0] KEEP_LAST  = CW'(N_KEEP - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(N_FRAME_LENGTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam bit            KEEP_ONE   = (N_KEEP == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEEP    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BWID-1:0] data_q, data_d;
    logic            dv_q, dv_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic            err_len_q, err_len_d;
    logic            err_head_q, err_head_d;
    logic            state_legal;

    // Next-state and output decode; every output defaults to an idle pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        head_d      = 1'b0;
        tail_d      = 1'b0;
        err_len_d   = 1'b0;
        err_head_d  = 1'b0;
        state_legal = (state_q == IDLE) || (state_q == KEEP) || (state_q == DISCARD);

        if (!state_legal) begin
            // Corrupted encoding: recover to a clean idle state.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (i_nd && i_head) begin
            // A head always opens a new trimmed frame, whatever state we are in.
            // Inside a frame it aborts the old one without emitting its tail.
            dv_d       = 1'b1;
            head_d     = 1'b1;
            data_d     = iv_data;
            cnt_d      = CNT_ONE;
            err_head_d = (state_q != IDLE);
            if (KEEP_ONE) begin
                tail_d  = 1'b1;
                state_d = DISCARD;
            end else begin
                state_d = KEEP;
            end
            if (i_tail) begin
                // One-sample frame: already finished, and certainly too short.
                err_len_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end
        end else if (i_nd) begin
            case (state_q)
                KEEP: begin
                    dv_d   = 1'b1;
                    data_d = iv_data;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (i_tail) begin
                        // Early tail: close the trimmed frame here.
                        tail_d    = 1'b1;
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (cnt_q == KEEP_LAST) begin
                        tail_d  = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (i_tail) begin
                        err_len_d = (cnt_q != FRAME_LAST);
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (cnt_q == FRAME_LAST) begin
                        // Tail missing at the expected position.
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    // IDLE: samples outside a frame are dropped.
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_head_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            err_len_q  <= err_len_d;
            err_head_q <= err_head_d;
        end
    end

    assign ov_data     = data_q;
    assign o_dv        = dv_q;
    assign o_head      = head_q;
    assign o_tail      = tail_q;
    assign o_err_len   = err_len_q;
    assign o_err_head  = err_head_q;
    assign o_dbg_state = state_q;

`ifdef XFRAMETRIM_STAT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (i_stat_clr) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (tail_q && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if ((err_len_q || err_head_q) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign ov_frame_cnt = frame_cnt_q;
    assign ov_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_xframetrim.sv
// Testbench for xframetrim with N_FRAME_LENGTH=16, N_KEEP=4.
// Directed vector table, a reset-abort sequence, random framed traffic
// against a frame-position reference model, and (with XFRAMETRIM_STAT_EN)
// the statistics counters.

module tb_xframetrim;

    localparam int BW  = 16;
    localparam int NFL = 16;
    localparam int NK  = 4;

    typedef struct packed {
        logic          dv;
        logic          hd;
        logic          tl;
        logic          el;
        logic          eh;
        logic [BW-1:0] data;
    } out_t;

    typedef struct {
        logic          nd;
        logic          h;
        logic          t;
        logic [BW-1:0] d;
        out_t          want;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] iv_data = '0;
    logic          i_nd = 1'b0;
    logic          i_head = 1'b0;
    logic          i_tail = 1'b0;
    logic [BW-1:0] ov_data;
    logic          o_dv, o_head, o_tail, o_err_len, o_err_head;
    logic [1:0]    dbg_state;
    logic          i_stat_clr = 1'b0;
    logic [15:0]   ov_frame_cnt, ov_err_cnt;

    always #5 clk = ~clk;

    xframetrim #(.BWID(BW), .N_FRAME_LENGTH(NFL), .N_KEEP(NK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iv_data      (iv_data),
        .i_nd         (i_nd),
        .i_head       (i_head),
        .i_tail       (i_tail),
        .ov_data      (ov_data),
        .o_dv         (o_dv),
        .o_head       (o_head),
        .o_tail       (o_tail),
        .o_err_len    (o_err_len),
        .o_err_head   (o_err_head),
`ifdef XFRAMETRIM_STAT_EN
        .i_stat_clr   (i_stat_clr),
        .ov_frame_cnt (ov_frame_cnt),
        .ov_err_cnt   (ov_err_cnt),
`endif
        .o_dbg_state  (dbg_state)
    );

`ifndef XFRAMETRIM_STAT_EN
    assign ov_frame_cnt = '0;
    assign ov_err_cnt   = '0;
`endif

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [$bits(out_t)-1:0] exp_q[$];
    logic [15:0] exp_fcnt = '0;
    logic [15:0] exp_ecnt = '0;
    vec_t vecs[$];

    // Reference model: tracks only "inside a frame" and the sample position.
    bit m_in_frame = 1'b0;
    int m_pos = 0;

    function automatic out_t model(logic nd, logic h, logic t, logic [BW-1:0] d);
        out_t e = '0;
        if (!nd) return e;
        if (h) begin
            e.dv = 1'b1; e.hd = 1'b1; e.data = d;
            e.eh = m_in_frame;
            e.tl = (NK == 1);
            if (t) begin
                e.el = 1'b1;
                m_in_frame = 1'b0;
            end else begin
                m_in_frame = 1'b1;
                m_pos = 1;
            end
        end else if (m_in_frame) begin
            if (m_pos < NK) begin
                e.dv = 1'b1; e.data = d;
            end
            if (t) begin
                e.tl = (m_pos < NK);
                e.el = (m_pos != NFL - 1);
                m_in_frame = 1'b0;
            end else begin
                if (m_pos == NK - 1) e.tl = 1'b1;
                if (m_pos == NFL - 1) begin
                    e.el = 1'b1;
                    m_in_frame = 1'b0;
                end else begin
                    m_pos++;
                end
            end
        end
        return e;
    endfunction

    // ---------------- checkers ----------------
    task automatic check_out(input string name, input out_t got, input out_t want);
        checks++;
        if ({got.dv, got.hd, got.tl, got.el, got.eh} !== {want.dv, want.hd, want.tl, want.el, want.eh}
            || (want.dv && (got.data !== want.data))) begin
            errors++;
            $display("FAIL %s: got dv/hd/tl/el/eh=%b data=%h, want %b data=%h", name,
                     {got.dv, got.hd, got.tl, got.el, got.eh}, got.data,
                     {want.dv, want.hd, want.tl, want.el, want.eh}, want.data);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic nd, input logic h, input logic t, input logic [BW-1:0] d,
                         output out_t got);
        @(negedge clk);
        i_nd = nd; i_head = h; i_tail = t; iv_data = d;
        @(posedge clk);
        #1;
        got = {o_dv, o_head, o_tail, o_err_len, o_err_head, ov_data};
    endtask

    task automatic run(input logic nd, input logic h, input logic t, input logic [BW-1:0] d,
                       input bit use_want, input out_t want, input string name);
        out_t m, e, got;
        m = model(nd, h, t, d);
        exp_q.push_back(use_want ? want : m);
        drive(nd, h, t, d, got);
`ifdef XFRAMETRIM_STAT_EN
        check_val({name, "_fcnt"}, {16'h0, ov_frame_cnt}, {16'h0, exp_fcnt});
        check_val({name, "_ecnt"}, {16'h0, ov_err_cnt}, {16'h0, exp_ecnt});
`endif
        e = exp_q.pop_front();
        check_out(name, got, e);
        if (e.tl && exp_fcnt != 16'hFFFF) exp_fcnt++;
        if ((e.el || e.eh) && exp_ecnt != 16'hFFFF) exp_ecnt++;
    endtask

    task automatic run_m(input logic nd, input logic h, input logic t, input logic [BW-1:0] d,
                         input string name);
        run(nd, h, t, d, 1'b0, '0, name);
    endtask

    function automatic void add(input logic nd, input logic h, input logic t, input logic [BW-1:0] d,
                                input logic dv, input logic hd, input logic tl, input logic el,
                                input logic eh);
        vec_t v;
        v.nd = nd; v.h = h; v.t = t; v.d = d;
        v.want = {dv, hd, tl, el, eh, d};
        vecs.push_back(v);
    endfunction

    task automatic send_frame(input int kind, input int f);
        int len;
        bit tail_end;
        case (kind)
            0, 1, 2: begin len = NFL; tail_end = 1'b1; end
            3:       begin len = $urandom_range(1, NFL - 1); tail_end = 1'b1; end
            4:       begin len = $urandom_range(NFL, NFL + 4); tail_end = 1'b0; end
            default: begin len = $urandom_range(2, NFL - 1); tail_end = 1'b0; end
        endcase
        if ($urandom_range(0, 4) == 0)
            run_m(1'b1, 1'b0, 1'($urandom_range(0, 1)), BW'($urandom), $sformatf("rnd%0d_junk", f));
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_m(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BW'($urandom),
                      $sformatf("rnd%0d_gap%0d", f, i));
            run_m(1'b1, (i == 0), tail_end && (i == len - 1), BW'($urandom),
                  $sformatf("rnd%0d_%0d", f, i));
        end
    endtask

    task automatic good_frame(input logic [BW-1:0] base, input string name);
        for (int i = 0; i < NFL; i++)
            run_m(1'b1, (i == 0), (i == NFL - 1), base + BW'(i), $sformatf("%s_%0d", name, i));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        out_t got;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", {11'h0, o_dv, o_head, o_tail, o_err_len, o_err_head, ov_data}, 32'h0);
        check_val("reset_stats", {ov_frame_cnt, ov_err_cnt}, 32'h0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < NFL; i++)                   // nominal 16-sample frame
            add(1, i == 0, i == NFL - 1, BW'(i), i < NK, i == 0, i == NK - 1, 0, 0);
        add(0, 1, 1, 16'hDEAD, 0, 0, 0, 0, 0);          // flags ignored without i_nd
        add(1, 1, 0, 16'h0030, 1, 1, 0, 0, 0);          // 3-sample frame, early tail
        add(1, 0, 0, 16'h0031, 1, 0, 0, 0, 0);
        add(1, 0, 1, 16'h0032, 1, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++)                     // head resync at index 9
            add(1, i == 0, 0, 16'h0040 + BW'(i), i < NK, i == 0, i == NK - 1, 0, 0);
        for (int i = 0; i < NFL; i++)
            add(1, i == 0, i == NFL - 1, 16'h0050 + BW'(i), i < NK, i == 0, i == NK - 1, 0, i == 0);
        for (int i = 0; i < NFL; i++)                   // missing tail
            add(1, i == 0, 0, 16'h0060 + BW'(i), i < NK, i == 0, i == NK - 1, i == NFL - 1, 0);
        add(1, 0, 0, 16'h0070, 0, 0, 0, 0, 0);          // dropped after the error
        for (int i = 0; i < vecs.size(); i++) begin
            out_t dummy;
            dummy = model(vecs[i].nd, vecs[i].h, vecs[i].t, vecs[i].d);
            m_in_frame = m_in_frame;
            exp_q.push_back(vecs[i].want);
            drive(vecs[i].nd, vecs[i].h, vecs[i].t, vecs[i].d, got);
`ifdef XFRAMETRIM_STAT_EN
            check_val($sformatf("vec%0d_fcnt", i), {16'h0, ov_frame_cnt}, {16'h0, exp_fcnt});
            check_val($sformatf("vec%0d_ecnt", i), {16'h0, ov_err_cnt}, {16'h0, exp_ecnt});
`endif
            dummy = exp_q.pop_front();
            check_out($sformatf("vec%0d", i), got, dummy);
            if (dummy.tl) exp_fcnt++;
            if (dummy.el || dummy.eh) exp_ecnt++;
        end

        // Reset asserted mid-frame aborts it immediately.
        run_m(1, 1, 0, 16'h0080, "rst_pre0");
        run_m(1, 0, 0, 16'h0081, "rst_pre1");
        @(negedge clk);
        i_nd = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outs", {11'h0, o_dv, o_head, o_tail, o_err_len, o_err_head, ov_data}, 32'h0);
        check_val("rst_mid_stats", {ov_frame_cnt, ov_err_cnt}, 32'h0);
        m_in_frame = 1'b0;
        exp_fcnt = '0;
        exp_ecnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        good_frame(16'h0090, "post_rst");

        // Random framed traffic with gaps.
        for (int f = 0; f < 40; f++)
            send_frame($urandom_range(0, 5), f);
        run_m(0, 0, 0, 16'h0, "rnd_flush");

`ifdef XFRAMETRIM_STAT_EN
        // Statistics: clear, then 3 good frames + early-tail + head resync.
        @(negedge clk);
        i_nd = 1'b0;
        i_stat_clr = 1'b1;
        @(posedge clk);
        #1;
        check_val("stat_clr_f", {16'h0, ov_frame_cnt}, 32'h0);
        check_val("stat_clr_e", {16'h0, ov_err_cnt}, 32'h0);
        @(negedge clk);
        i_stat_clr = 1'b0;
        exp_fcnt = '0;
        exp_ecnt = '0;
        good_frame(16'h0100, "st_g1");
        run_m(1, 1, 0, 16'h0200, "st_e0");
        run_m(1, 0, 0, 16'h0201, "st_e1");
        run_m(1, 0, 1, 16'h0202, "st_e2");
        run_m(1, 1, 0, 16'h0300, "st_r0");
        run_m(1, 0, 0, 16'h0301, "st_r1");
        good_frame(16'h0400, "st_g2");
        good_frame(16'h0500, "st_g3");
        run_m(0, 0, 0, 16'h0, "st_idle");
        check_val("stat_frames", {16'h0, ov_frame_cnt}, 32'd4);
        check_val("stat_errs", {16'h0, ov_err_cnt}, 32'd2);
        @(negedge clk);
        i_stat_clr = 1'b1;
        @(posedge clk);
        #1;
        check_val("stat_clr2_f", {16'h0, ov_frame_cnt}, 32'h0);
        check_val("stat_clr2_e", {16'h0, ov_err_cnt}, 32'h0);
        @(negedge clk);
        i_stat_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
